// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants and types for the MIPS fetch stage:
//               opcode/funct values, NOP encoding, default reset PC,
//               fetch-stage state encoding and the branch-offset helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Primary opcodes and SPECIAL-group funct codes seen by the fetch stage
    localparam logic [5:0] OP_SPECIAL    = 6'h00;
    localparam logic [5:0] OP_J          = 6'h02;
    localparam logic [5:0] OP_JAL        = 6'h03;
    localparam logic [5:0] OP_BEQ        = 6'h04;
    localparam logic [5:0] FUNCT_JR      = 6'h08;
    localparam logic [5:0] FUNCT_SYSCALL = 6'h0C;

    // sll $0,$0,0 - the canonical bubble word
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Fetch-stage state, explicit one-bit encoding
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } if_state_e;

    // Sign-extended, word-scaled branch displacement
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/pc_next_calc.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_calc
// Description : Combinational next-fetch-address selector.
//               Priority: jr > jmp > branch > sequential (fetch_pc + 4).
// Ports       : fetch_pc  - current fetch address
//               pc_plus4  - address of the instruction in ir, plus 4
//               ir        - current instruction register
//               jr_target - rs value for jr
//               sel_jr / sel_jmp / sel_br - qualified redirect requests
//               next_pc   - selected next fetch address
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next_calc
    import mips_pkg::*;
(
    input  logic [31:0] fetch_pc,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] ir,
    input  logic [31:0] jr_target,
    input  logic        sel_jr,
    input  logic        sel_jmp,
    input  logic        sel_br,
    output logic [31:0] next_pc
);

    // Opcode field and jr_target low bits play no part in target math
    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, ir[31:26], jr_target[1:0]};

    always_comb begin
        next_pc = fetch_pc + 32'd4;
        if (sel_jr) begin
            // Force word alignment of the register target
            next_pc = {jr_target[31:2], 2'b00};
        end else if (sel_jmp) begin
            // Region bits come from the delay-slot-free successor address
            next_pc = {pc_plus4[31:28], ir[25:0], 2'b00};
        end else if (sel_br) begin
            next_pc = pc_plus4 + branch_offset(ir[15:0]);
        end
    end

endmodule : pc_next_calc
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : MIPS instruction-fetch stage. Holds the fetch PC, drives the
//               asynchronous instruction ROM, latches the returned word into
//               ir, and handles sequential / branch / j / jr flow, stall,
//               squash-on-redirect and syscall halt with go-resume.
// Ports       : clk, rst_n (sync, active-low)
//               imem_addr / imem_rdata     - instruction ROM interface
//               stall                      - hold all fetch state
//               branch_taken, jmp, jr, jr_target, syscall - decode of ir
//               go                         - resume pulse from HALT
//               ir, ir_valid, pc, pc_plus4 - instruction register outputs
//               halted                     - stage parked in HALT
// Options     : IF_PERF_CNT_EN adds cyc_cnt / inst_cnt counter outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter bit          HALT_ON_SYSCALL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic        jmp,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        syscall,
    input  logic        go,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        halted
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] cyc_cnt,
    output logic [31:0] inst_cnt
`endif
);

    if_state_e   r_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_ir;
    logic        r_ir_valid;
    logic [31:0] r_pc;
    logic        r_halted;

    logic        w_sel_jr;
    logic        w_sel_jmp;
    logic        w_sel_br;
    logic        w_redirect;
    logic        w_sys_halt;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;

    // Decode inputs only mean something when ir holds a real instruction
    assign w_sel_jr   = r_ir_valid & jr;
    assign w_sel_jmp  = r_ir_valid & jmp;
    assign w_sel_br   = r_ir_valid & branch_taken;
    assign w_redirect = w_sel_jr | w_sel_jmp | w_sel_br;
    assign w_sys_halt = r_ir_valid & syscall & HALT_ON_SYSCALL;

    assign w_pc_plus4 = r_pc + 32'd4;

    pc_next_calc u_pc_next_calc (
        .fetch_pc  (r_fetch_pc),
        .pc_plus4  (w_pc_plus4),
        .ir        (r_ir),
        .jr_target (jr_target),
        .sel_jr    (w_sel_jr),
        .sel_jmp   (w_sel_jmp),
        .sel_br    (w_sel_br),
        .next_pc   (w_next_pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_fetch_pc <= RESET_PC;
            r_ir       <= NOP_WORD;
            r_ir_valid <= 1'b0;
            r_pc       <= RESET_PC;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!stall) begin
                        if (w_sys_halt) begin
                            // fetch_pc already points at syscall pc + 4
                            r_state    <= ST_HALT;
                            r_halted   <= 1'b1;
                            r_ir       <= NOP_WORD;
                            r_ir_valid <= 1'b0;
                        end else if (w_redirect) begin
                            // Squash the word fetched this cycle: one bubble
                            r_fetch_pc <= w_next_pc;
                            r_ir       <= NOP_WORD;
                            r_ir_valid <= 1'b0;
                        end else begin
                            r_ir       <= imem_rdata;
                            r_ir_valid <= 1'b1;
                            r_pc       <= r_fetch_pc;
                            r_fetch_pc <= w_next_pc;
                        end
                    end
                end
                ST_HALT: begin
                    if (go) begin
                        r_state  <= ST_RUN;
                        r_halted <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_cyc_cnt;
    logic [31:0] r_inst_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cyc_cnt  <= 32'd0;
            r_inst_cnt <= 32'd0;
        end else begin
            if (r_state != ST_HALT) begin
                r_cyc_cnt <= r_cyc_cnt + 32'd1;
            end
            if (r_ir_valid && !stall) begin
                r_inst_cnt <= r_inst_cnt + 32'd1;
            end
        end
    end

    assign cyc_cnt  = r_cyc_cnt;
    assign inst_cnt = r_inst_cnt;
`endif

    assign imem_addr = r_fetch_pc;
    assign ir        = r_ir;
    assign ir_valid  = r_ir_valid;
    assign pc        = r_pc;
    assign pc_plus4  = w_pc_plus4;
    assign halted    = r_halted;

endmodule : if_stage
`default_nettype wire
